// File: rtl/alu_pkg.sv
// Shared encodings and helpers for the sequential signed ALU.
package alu_pkg;

   localparam int unsigned MAX_W = 64;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      FIX  = 2'd2
   } state_e;

   // Two's-complement magnitude of a sign-extended value; callers truncate to their width.
   function automatic logic [MAX_W-1:0] mag_of(input logic [MAX_W-1:0] x);
      return x[MAX_W-1] ? (~x + MAX_W'(1)) : x;
   endfunction

endpackage

// File: rtl/mag_conv.sv
// Signed value to sign-magnitude view; the most negative input maps to 2^(N-1).
module mag_conv #(
   parameter int unsigned N = 4
) (
   input  logic signed [N-1:0] x,
   output logic                sign,
   output logic        [N-1:0] mag
);

   assign sign = x[N-1];
   assign mag  = sign ? (N'(~x) + N'(1)) : N'(x);

endmodule

// File: rtl/alu_seq.sv
// Handshaked signed ALU: single-cycle add/sub, W-cycle shift-add multiply, sign-magnitude views.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned W = 4
) (
   input  logic             clk,
   input  logic             ar,
   input  logic             start,
   input  logic [1:0]       select,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [2*W-1:0]   f,
   output logic             sign,
   output logic [2*W-1:0]   f_mag,
   output logic             signA,
   output logic             signB,
   output logic [W-1:0]     a_mag,
   output logic [W-1:0]     b_mag
);

   localparam int unsigned FW = 2 * W;
   localparam int unsigned CW = $clog2(W + 1);

   state_e          state_q, state_d;
   logic [1:0]      op_q, op_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [FW-1:0]   acc_q, acc_d;
   logic [FW-1:0]   mcand_q, mcand_d;
   logic [W-1:0]    mplier_q, mplier_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [FW-1:0]   f_q, f_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            err_q, err_d;

   logic [W-1:0]    a_live_mag_c;
   logic [W-1:0]    b_live_mag_c;

   assign a_live_mag_c = W'(mag_of(MAX_W'($signed(a))));
   assign b_live_mag_c = W'(mag_of(MAX_W'($signed(b))));

   // Next-state and datapath; done/err default low so they only pulse.
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      f_d      = f_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d = select;
               a_d  = a;
               b_d  = b;
               case (select)
                  OP_ADD: begin
                     f_d    = FW'($signed(a)) + FW'($signed(b));
                     done_d = 1'b1;
                  end
                  OP_SUB: begin
                     f_d    = FW'($signed(a)) - FW'($signed(b));
                     done_d = 1'b1;
                  end
                  OP_MUL: begin
                     acc_d    = '0;
                     mcand_d  = FW'(a_live_mag_c);
                     mplier_d = b_live_mag_c;
                     cnt_d    = '0;
                     busy_d   = 1'b1;
                     state_d  = MUL;
                  end
                  default: begin
                     done_d = 1'b1;
                     err_d  = 1'b1;
                  end
               endcase
            end
         end

         MUL: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + (mcand_q << cnt_q);
            end
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               state_d = FIX;
            end
         end

         FIX: begin
            // Unsigned magnitude product gets its sign applied here.
            if (op_q == OP_MUL) begin
               f_d = (signA ^ signB) ? (~acc_q + FW'(1)) : acc_q;
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
         end

         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge ar) begin
      if (ar) begin
         state_q  <= IDLE;
         op_q     <= OP_ADD;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         f_q      <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         f_q      <= f_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;
   assign f    = f_q;

   mag_conv #(.N(FW)) u_mag_f (
      .x    (f_q),
      .sign (sign),
      .mag  (f_mag)
   );

   mag_conv #(.N(W)) u_mag_a (
      .x    (a_q),
      .sign (signA),
      .mag  (a_mag)
   );

   mag_conv #(.N(W)) u_mag_b (
      .x    (b_q),
      .sign (signB),
      .mag  (b_mag)
   );

endmodule

// File: tb/tb_alu_seq.sv
// Randomised and directed checks of alu_seq at W=4 and W=8 against an integer-arithmetic model.
module tb_alu_seq;

   logic clk = 1'b0;
   logic ar;
   always #5 clk = ~clk;

   logic       start4, busy4, done4, err4, sign4, sa4, sb4;
   logic [1:0] sel4;
   logic [3:0] a4, b4, am4, bm4;
   logic [7:0] f4, fm4;

   logic        start8, busy8, done8, err8, sign8, sa8, sb8;
   logic [1:0]  sel8;
   logic [7:0]  a8, b8, am8, bm8;
   logic [15:0] f8, fm8;

   alu_seq #(.W(4)) dut4 (
      .clk(clk), .ar(ar), .start(start4), .select(sel4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .err(err4), .f(f4), .sign(sign4), .f_mag(fm4),
      .signA(sa4), .signB(sb4), .a_mag(am4), .b_mag(bm4)
   );

   alu_seq #(.W(8)) dut8 (
      .clk(clk), .ar(ar), .start(start8), .select(sel8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .err(err8), .f(f8), .sign(sign8), .f_mag(fm8),
      .signA(sa8), .signB(sb8), .a_mag(am8), .b_mag(bm8)
   );

   int     n_chk  = 0;
   int     n_fail = 0;
   longint ref_f4 = 0;
   longint ref_f8 = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int w, input logic st, input logic [1:0] s,
                        input logic [7:0] x, input logic [7:0] y);
      if (w == 4) begin
         start4 = st; sel4 = s; a4 = x[3:0]; b4 = y[3:0];
      end else begin
         start8 = st; sel8 = s; a8 = x; b8 = y;
      end
   endtask

   task automatic idle_drive(input int w);
      drive(w, 1'b0, 2'($urandom), 8'($urandom), 8'($urandom));
   endtask

   // k: 0 f, 1 f_mag, 2 sign, 3 signA, 4 signB, 5 a_mag, 6 b_mag, other {busy,done,err}
   function automatic logic [63:0] obs(input int w, input int k);
      if (w == 4) begin
         case (k)
            0: return 64'(f4);
            1: return 64'(fm4);
            2: return 64'(sign4);
            3: return 64'(sa4);
            4: return 64'(sb4);
            5: return 64'(am4);
            6: return 64'(bm4);
            default: return 64'({busy4, done4, err4});
         endcase
      end else begin
         case (k)
            0: return 64'(f8);
            1: return 64'(fm8);
            2: return 64'(sign8);
            3: return 64'(sa8);
            4: return 64'(sb8);
            5: return 64'(am8);
            6: return 64'(bm8);
            default: return 64'({busy8, done8, err8});
         endcase
      end
   endfunction

   function automatic longint labs(input longint v);
      return (v < 0) ? -v : v;
   endfunction

   function automatic longint model(input longint cur, input logic [1:0] s,
                                    input longint x, input longint y);
      case (s)
         2'b00:   return x + y;
         2'b01:   return x - y;
         2'b10:   return x * y;
         default: return cur;
      endcase
   endfunction

   // One accepted operation, optionally re-pulsing start while the multiply is in flight.
   task automatic do_op(input int w, input logic [1:0] s, input logic [7:0] x,
                        input logic [7:0] y, input bit poke);
      longint     sx, sy, e, m;
      int         n, bcnt, lat_exp, bcnt_exp;
      logic [2:0] c;
      sx = (w == 4) ? longint'($signed(x[3:0])) : longint'($signed(x));
      sy = (w == 4) ? longint'($signed(y[3:0])) : longint'($signed(y));
      e  = model((w == 4) ? ref_f4 : ref_f8, s, sx, sy);
      if (w == 4) ref_f4 = e; else ref_f8 = e;
      m        = (longint'(1) << (2 * w)) - 1;
      lat_exp  = (s == 2'b10) ? w + 2 : 1;
      bcnt_exp = (s == 2'b10) ? w + 1 : 0;

      drive(w, 1'b1, s, x, y);
      @(negedge clk);
      idle_drive(w);
      n    = 1;
      bcnt = 0;
      c    = 3'(obs(w, 7));
      while (c[1] !== 1'b1 && n < 64) begin
         if (c[2] === 1'b1) bcnt++;
         if (poke && n == 2) drive(w, 1'b1, 2'b00, 8'($urandom), 8'($urandom));
         else idle_drive(w);
         @(negedge clk);
         n++;
         c = 3'(obs(w, 7));
      end
      check("latency",  64'(n), 64'(lat_exp));
      check("busy_cyc", 64'(bcnt), 64'(bcnt_exp));
      check("err",      64'(c[0]), 64'(s == 2'b11));
      check("f",        obs(w, 0), 64'(e & m));
      check("f_mag",    obs(w, 1), 64'(labs(e)));
      check("sign",     obs(w, 2), 64'(e < 0));
      check("signA",    obs(w, 3), 64'(sx < 0));
      check("signB",    obs(w, 4), 64'(sy < 0));
      check("a_mag",    obs(w, 5), 64'(labs(sx)));
      check("b_mag",    obs(w, 6), 64'(labs(sy)));
      idle_drive(w);
      @(negedge clk);
      c = 3'(obs(w, 7));
      check("pulse_end", 64'(c), 64'(0));
   endtask

   initial begin
      logic [2:0] c;
      bit         seen;

      ar = 1'b1;
      drive(4, 1'b0, 2'b00, 8'h00, 8'h00);
      drive(8, 1'b0, 2'b00, 8'h00, 8'h00);
      repeat (2) @(negedge clk);
      check("rst_f4",   obs(4, 0), 64'(0));
      check("rst_ctl4", obs(4, 7), 64'(0));
      check("rst_mag4", {obs(4, 3), obs(4, 5)}, 64'(0));
      check("rst_f8",   obs(8, 0), 64'(0));
      check("rst_ctl8", obs(8, 7), 64'(0));
      ar = 1'b0;
      @(negedge clk);

      do_op(4, 2'b00, 8'h03, 8'h0B, 1'b0);
      check("tp_add", obs(4, 0), 64'h0FE);
      do_op(4, 2'b10, 8'h07, 8'h0D, 1'b0);
      check("tp_mul", obs(4, 0), 64'h0EB);
      do_op(4, 2'b10, 8'h08, 8'h08, 1'b0);
      check("tp_mul_neg", obs(4, 0), 64'h040);
      do_op(4, 2'b01, 8'h08, 8'h07, 1'b0);
      check("tp_sub", obs(4, 0), 64'h0F1);
      do_op(4, 2'b10, 8'h05, 8'h03, 1'b1);
      do_op(4, 2'b10, 8'h0B, 8'h06, 1'b1);
      do_op(4, 2'b00, 8'h02, 8'h03, 1'b0);
      do_op(4, 2'b11, 8'h01, 8'h0F, 1'b0);
      check("tp_ill_hold", obs(4, 0), 64'h005);

      // Back-to-back adds: accept in the done cycle.
      drive(4, 1'b1, 2'b00, 8'h03, 8'h04);
      @(negedge clk);
      c = 3'(obs(4, 7));
      check("b2b_done1", 64'(c), 64'(3'b010));
      check("b2b_f1", obs(4, 0), 64'h07);
      drive(4, 1'b1, 2'b01, 8'h02, 8'h06);
      @(negedge clk);
      c = 3'(obs(4, 7));
      check("b2b_done2", 64'(c), 64'(3'b010));
      check("b2b_f2", obs(4, 0), 64'hFC);
      ref_f4 = -4;
      idle_drive(4);
      @(negedge clk);

      // Asynchronous reset in the middle of a multiply.
      drive(4, 1'b1, 2'b10, 8'h07, 8'h05);
      @(negedge clk);
      idle_drive(4);
      @(negedge clk);
      #2 ar = 1'b1;
      #1;
      check("arst_f",   obs(4, 0), 64'(0));
      check("arst_ctl", obs(4, 7), 64'(0));
      check("arst_f8",  obs(8, 0), 64'(0));
      @(negedge clk);
      ar     = 1'b0;
      ref_f4 = 0;
      ref_f8 = 0;
      seen   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done4 !== 1'b0 || busy4 !== 1'b0) seen = 1'b1;
      end
      check("arst_no_done", 64'(seen), 64'(0));
      do_op(4, 2'b00, 8'h06, 8'h01, 1'b0);

      do_op(8, 2'b10, 8'h80, 8'h7F, 1'b0);
      check("tp_mul8", obs(8, 0), 64'hC080);
      do_op(8, 2'b11, 8'h12, 8'h34, 1'b0);
      check("tp_ill8", obs(8, 0), 64'hC080);
      do_op(8, 2'b10, 8'h80, 8'h80, 1'b0);

      for (int i = 0; i < 40; i++) begin
         do_op(4, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
         do_op(8, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
